// File: rtl/csr_row_sched_if.sv
// csr_row_sched_if: control, row-pointer RAM and nonzero-stream signals of the CSR row scheduler
interface csr_row_sched_if #(
  parameter int ROW_AW = 10,
  parameter int NZ_AW  = 14
);
  logic              start;
  logic [ROW_AW-1:0] num_rows;
  logic              stall;
  logic [ROW_AW-1:0] row_addr;
  logic [31:0]       row_data;
  logic [NZ_AW-1:0]  nz_addr;
  logic              nz_valid;
  logic              nz_first;
  logic              nz_last;
  logic [ROW_AW-1:0] nz_row;
  logic              empty_row;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output start, num_rows, stall, row_data,
    input  row_addr, nz_addr, nz_valid, nz_first, nz_last, nz_row, empty_row, busy, done, err
  );
  modport slave (
    input  start, num_rows, stall, row_data,
    output row_addr, nz_addr, nz_valid, nz_first, nz_last, nz_row, empty_row, busy, done, err
  );
endinterface

// File: rtl/csr_row_sched.sv
// csr_row_sched: walks the CSR row-pointer RAM and issues one nonzero address per cycle; define CSR_EMPTY_ROW_EN to emit empty-row markers
module csr_row_sched #(
  parameter int ROW_AW = 10,
  parameter int NZ_AW  = 14
) (
  input logic           clk,
  input logic           rst_n,
  csr_row_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRE0, PRE1, WAIT, LOAD, STREAM, EMPTY, DONE} state_t;
  state_t            state_q, state_d;
  logic [ROW_AW-1:0] row_addr_q, row_addr_d;
  logic [ROW_AW-1:0] row_idx_q, row_idx_d;
  logic [ROW_AW-1:0] num_q, num_d;
  logic [NZ_AW-1:0]  beg_q, beg_d;
  logic [NZ_AW-1:0]  end_q, end_d;
  logic [NZ_AW-1:0]  nz_addr_q, nz_addr_d;
  logic              err_q, err_d;
  logic              bad_q, bad_d;
  logic [NZ_AW-1:0]  ptr;
  logic              unused_ptr_hi;
  logic              last_row, last_beat, empty_go, advance;
  logic              valid, empty_mark;
  assign ptr           = bus.row_data[NZ_AW-1:0];
  assign unused_ptr_hi = ^bus.row_data[31:NZ_AW];
  assign last_row      = row_idx_q == num_q - ROW_AW'(1);
  assign last_beat     = nz_addr_q == end_q - NZ_AW'(1);
`ifdef CSR_EMPTY_ROW_EN
  assign empty_go      = !bus.stall;
  assign empty_mark    = state_q == EMPTY;
`else
  assign empty_go      = 1'b1;
  assign empty_mark    = 1'b0;
`endif
  assign valid         = state_q == STREAM;
  assign advance       = (valid && !bus.stall && last_beat) || (state_q == EMPTY && empty_go);
  // next-state: row walk, pointer capture and the shared row-advance step
  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    row_idx_d  = row_idx_q;
    num_d      = num_q;
    beg_d      = beg_q;
    end_d      = end_q;
    nz_addr_d  = nz_addr_q;
    err_d      = err_q;
    bad_d      = bad_q;
    case (state_q)
      IDLE: if (bus.start) begin
        err_d      = 1'b0;
        num_d      = bus.num_rows;
        row_addr_d = '0;
        row_idx_d  = '0;
        state_d    = (bus.num_rows != '0) ? PRE0 : DONE;
      end
      PRE0: begin
        row_addr_d = ROW_AW'(1);
        state_d    = PRE1;
      end
      PRE1: begin
        beg_d   = ptr;
        state_d = LOAD;
      end
      LOAD: begin
        end_d     = ptr;
        bad_d     = ptr < beg_q;
        err_d     = err_q | (ptr < beg_q);
        nz_addr_d = (ptr > beg_q) ? beg_q : nz_addr_q;
        state_d   = (ptr > beg_q) ? STREAM : EMPTY;
      end
      STREAM: nz_addr_d = (!bus.stall && !last_beat) ? nz_addr_q + NZ_AW'(1) : nz_addr_q;
      WAIT: state_d = LOAD;
      DONE: state_d = IDLE;
      default: ;
    endcase
    if (advance) begin
      beg_d      = bad_q ? beg_q : end_q;
      state_d    = last_row ? DONE : WAIT;
      row_idx_d  = last_row ? row_idx_q : row_idx_q + ROW_AW'(1);
      row_addr_d = last_row ? row_addr_q : row_idx_q + ROW_AW'(2);
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_addr_q <= '0;
      row_idx_q  <= '0;
      num_q      <= '0;
      beg_q      <= '0;
      end_q      <= '0;
      nz_addr_q  <= '0;
      err_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_addr_q <= row_addr_d;
      row_idx_q  <= row_idx_d;
      num_q      <= num_d;
      beg_q      <= beg_d;
      end_q      <= end_d;
      nz_addr_q  <= nz_addr_d;
      err_q      <= err_d;
      bad_q      <= bad_d;
    end
  end
  assign bus.row_addr  = row_addr_q;
  assign bus.nz_addr   = nz_addr_q;
  assign bus.nz_valid  = valid;
  assign bus.nz_first  = valid && nz_addr_q == beg_q;
  assign bus.nz_last   = valid && last_beat;
  assign bus.nz_row    = (valid || empty_mark) ? row_idx_q : '0;
  assign bus.empty_row = empty_mark;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_csr_row_sched.sv
// tb_csr_row_sched: directed vectors against a row-pointer walk model of the scheduler
module tb_csr_row_sched;
  localparam int RA = 10;
  localparam int NA = 14;
`ifdef CSR_EMPTY_ROW_EN
  localparam int EMPTY_EN = 1;
`else
  localparam int EMPTY_EN = 0;
`endif
  typedef struct packed {
    logic          e;
    logic [RA-1:0] r;
    logic [NA-1:0] a;
    logic          f;
    logic          l;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  csr_row_sched_if #(.ROW_AW(RA), .NZ_AW(NA)) bus();
  csr_row_sched #(.ROW_AW(RA), .NZ_AW(NA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] ram [0:15];
  always @(posedge clk) bus.row_data <= ram[bus.row_addr[3:0]];
  int n_chk = 0, n_fail = 0;
  int n_empty = 0, n_a1 = 0, n_acc = 0, n_vis = 0;
  beat_t exp_q[$];
  logic  exp_err = 1'b0;
  beat_t b, o;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] beat_vec();
    return 64'({bus.nz_valid, bus.nz_addr, bus.nz_first, bus.nz_last, bus.nz_row});
  endfunction
  function automatic logic [63:0] all_out();
    return 64'({bus.row_addr, bus.nz_addr, bus.nz_row, bus.nz_valid, bus.nz_first, bus.nz_last,
                bus.empty_row, bus.busy, bus.done, bus.err});
  endfunction
  // model: expand the pointer list into the beats a correct scheduler must emit
  task automatic load(input int n, input int p0, input int p1, input int p2, input int p3);
    int p[4];
    int beg;
    p = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) ram[i] = 32'hFFFF_C000 | 32'(p[i]);
    exp_q.delete();
    exp_err = 1'b0;
    beg = p[0];
    for (int r = 0; r < n; r++) begin
      if (p[r+1] > beg) begin
        for (int a = beg; a < p[r+1]; a++)
          exp_q.push_back('{e: 1'b0, r: RA'(r), a: NA'(a), f: (a == beg), l: (a == p[r+1] - 1)});
        beg = p[r+1];
      end else begin
        if (p[r+1] < beg) exp_err = 1'b1;
        if (EMPTY_EN != 0) exp_q.push_back('{e: 1'b1, r: RA'(r), a: '0, f: 1'b0, l: 1'b0});
      end
    end
  endtask
  // scoreboard: every shown beat must match the model head; it retires only when not stalled
  always @(negedge clk) if (rst_n) begin
    if (bus.nz_valid || bus.empty_row) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        b = exp_q[0];
        o.e = bus.empty_row;
        o.r = bus.nz_row;
        o.a = bus.empty_row ? '0 : bus.nz_addr;
        o.f = bus.empty_row ? 1'b0 : bus.nz_first;
        o.l = bus.empty_row ? 1'b0 : bus.nz_last;
        chk("beat_kind", 64'({bus.nz_valid, bus.empty_row}), 64'({!b.e, b.e}));
        chk("beat", 64'(o), 64'(b));
        if (!bus.stall) void'(exp_q.pop_front());
      end
    end
    if (bus.nz_valid) n_vis++;
    if (bus.nz_valid && !bus.stall) n_acc++;
    if (bus.nz_valid && bus.nz_addr == NA'(1)) n_a1++;
    if (bus.empty_row) n_empty++;
    if (bus.done) begin
      chk("done_drained", 64'(exp_q.size()), 64'd0);
      chk("done_err", 64'(bus.err), 64'(exp_err));
      chk("done_busy", 64'(bus.busy), 64'd1);
    end
  end
  task automatic go(input int n);
    @(posedge clk); #1;
    bus.num_rows = RA'(n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!bus.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(bus.done), 64'd1);
    @(negedge clk);
  endtask
  // ptr={0,2,3}, two rows, with cycle-exact expectations after the accepting edge
  task automatic run_basic(input string tag);
    load(2, 0, 2, 3, 0);
    go(2);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, "_t1"}, 64'({bus.busy, bus.row_addr}), 64'({1'b1, 10'd0}));
      if (n == 2) chk({tag, "_t2"}, 64'(bus.row_addr), 64'd1);
      if (n == 4) chk({tag, "_t4"}, beat_vec(), 64'({1'b1, 14'd0, 1'b1, 1'b0, 10'd0}));
      if (n == 5) chk({tag, "_t5"}, beat_vec(), 64'({1'b1, 14'd1, 1'b0, 1'b1, 10'd0}));
      if (n == 6) chk({tag, "_t6"}, 64'({bus.nz_valid, bus.row_addr}), 64'({1'b0, 10'd2}));
      if (n == 7) chk({tag, "_t7"}, 64'(bus.nz_valid), 64'd0);
      if (n == 8) chk({tag, "_t8"}, beat_vec(), 64'({1'b1, 14'd2, 1'b1, 1'b1, 10'd1}));
      if (n == 9) chk({tag, "_t9"}, 64'({bus.done, bus.busy}), 64'd3);
      if (n == 10) chk({tag, "_t10"}, 64'({bus.done, bus.busy}), 64'd0);
    end
  endtask
  initial begin
    int k;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    bus.start = 1'b0;
    bus.num_rows = '0;
    bus.stall = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_values", all_out(), 64'd0);
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    run_basic("s1");
    n_empty = 0; n_acc = 0;
    load(2, 0, 0, 2, 0);
    go(2);
    wait_done("s2_done");
    chk("s2_empty_pulses", 64'(n_empty), 64'(EMPTY_EN));
    chk("s2_beats", 64'(n_acc), 64'd2);
    n_a1 = 0; n_acc = 0;
    load(1, 0, 3, 0, 0);
    go(1);
    k = 0;
    while (!(bus.nz_valid && bus.nz_addr == NA'(1)) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("s3_reach_addr1", 64'(bus.nz_valid && bus.nz_addr == NA'(1)), 64'd1);
    bus.stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("s3_held", beat_vec(), 64'({1'b1, 14'd1, 1'b0, 1'b0, 10'd0}));
    bus.stall = 1'b0;
    wait_done("s3_done");
    chk("s3_addr1_cycles", 64'(n_a1), 64'd4);
    chk("s3_beats", 64'(n_acc), 64'd3);
    load(3, 0, 5, 3, 7);
    go(3);
    wait_done("s4_done");
    chk("s4_err_sticky", 64'(bus.err), 64'd1);
    n_vis = 0;
    load(0, 0, 0, 0, 0);
    go(0);
    @(negedge clk);
    chk("s6_zero_done", 64'({bus.done, bus.busy, bus.err}), 64'({1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    chk("s6_zero_idle", 64'({bus.done, bus.busy, n_vis}), 64'd0);
    load(2, 0, 2, 3, 0);
    go(2);
    @(posedge clk); #1;
    bus.num_rows = RA'(5);
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("s6b_done_seen", 64'(bus.done), 64'd1);
    bus.num_rows = RA'(2);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk) chk("s6b_ignored_a", 64'(bus.busy), 64'd0);
    @(negedge clk) chk("s6b_ignored_b", 64'(bus.busy), 64'd0);
    load(2, 0, 2, 3, 0);
    go(2);
    repeat (4) @(negedge clk);
    chk("s5_in_stream", 64'(bus.nz_valid), 64'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 chk("s5_async_clear", all_out(), 64'd0);
    @(negedge clk) chk("s5_reset_hold", all_out(), 64'd0);
    #2 rst_n = 1'b1;
    run_basic("s5");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end
endmodule
